// File: rtl/uart_fifo_param.sv
// rtl/uart_fifo_param.sv - parametrised strobe-driven FIFO between the UART and the SDIO register side
// Active-low push/pop strobes act on their falling edge; status flags are active-low.
module uart_fifo_param #(
  parameter int DW       = 8,
  parameter int AW       = 4,
  parameter int AF_LEVEL = (1 << AW) - 2,
  parameter int AE_LEVEL = 1,
  parameter bit FWFT     = 1'b0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_n,
  input  logic          rd_n,
  input  logic [DW-1:0] idat,
  input  logic          clr_err,
  output logic [DW-1:0] odat,
  output logic          full_n,
  output logic          empty_n,
  output logic          afull_n,
  output logic          aempty_n,
  output logic [AW:0]   level,
  output logic          ovf,
  output logic          udf
);

  localparam int DEPTH = 1 << AW;
  localparam logic [AW:0] DEPTH_LV = (AW+1)'(DEPTH);
  localparam logic [AW:0] AF_LV    = (AW+1)'(AF_LEVEL);
  localparam logic [AW:0] AE_LV    = (AW+1)'(AE_LEVEL);

  logic          wr_q, rd_q;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   level_q, level_d;
  logic          ovf_q, ovf_d, udf_q, udf_d;
  logic          push_ev, pop_ev, push_ok, pop_ok;
  logic [DW-1:0] mem_q [DEPTH];

  // A pop frees a slot on the same edge, so a push at full still lands.
  always_comb begin
    push_ev  = wr_q & ~wr_n;
    pop_ev   = rd_q & ~rd_n;
    pop_ok   = pop_ev & (level_q != '0);
    push_ok  = push_ev & ((level_q != DEPTH_LV) | pop_ok);
    wr_ptr_d = wr_ptr_q + AW'(push_ok);
    rd_ptr_d = rd_ptr_q + AW'(pop_ok);
    level_d  = level_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
    ovf_d    = (ovf_q & ~clr_err) | (push_ev & ~push_ok);
    udf_d    = (udf_q & ~clr_err) | (pop_ev & ~pop_ok);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_q     <= 1'b0;
      rd_q     <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_q     <= wr_n;
      rd_q     <= rd_n;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= idat;
  end

  if (FWFT) begin : g_fwft
    assign odat = mem_q[rd_ptr_q];
  end else begin : g_reg
    logic [DW-1:0] odat_q;
    always_ff @(posedge clk or negedge rst) begin
      if (!rst)        odat_q <= '0;
      else if (pop_ok) odat_q <= mem_q[rd_ptr_q];
    end
    assign odat = odat_q;
  end

  assign level    = level_q;
  assign full_n   = (level_q != DEPTH_LV);
  assign empty_n  = (level_q != '0);
  assign afull_n  = !(level_q >= AF_LV);
  assign aempty_n = !(level_q <= AE_LV);
  assign ovf      = ovf_q;
  assign udf      = udf_q;

endmodule

// File: doc/uart_fifo_param.md
# uart_fifo_param

Parametrised byte/word FIFO with strobe-edge push/pop, the buffering stage between the UART8N1 transmitter/receiver and the SDIO-side register interface. It generalises the team's 8x15 FIFO: configurable width and depth, full use of all 2^AW entries, occupancy output, almost-full/almost-empty thresholds, sticky overflow/underflow flags and an optional first-word-fall-through read mode. Push and pop remain triggered by falling edges of active-low strobes. Status flags remain active-low.

## Interface
- DW, 8: data width in bits.
- AW, 4: address width; DEPTH = 2^AW entries, all usable.
- AF_LEVEL, 2^AW-2: afull_n asserts (low) when level >= AF_LEVEL.
- AE_LEVEL, 1: aempty_n asserts (low) when level <= AE_LEVEL.
- FWFT, 0: 0 = registered read on pop; 1 = head word shown continuously.

- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-low.
- wr_n  in  1  push strobe; the falling edge pushes idat.
- rd_n  in  1  pop strobe; the falling edge pops.
- idat  in  DW  write data, sampled on the push edge.
- clr_err  in  1  synchronous, active-high clear of ovf and udf.
- odat  out  DW  read data.
- full_n  out  1  low when level == DEPTH.
- empty_n  out  1  low when level == 0.
- afull_n  out  1  low when level >= AF_LEVEL.
- aempty_n  out  1  low when level <= AE_LEVEL.
- level  out  AW+1  occupancy, 0..DEPTH.
- ovf  out  1  sticky; set by a rejected push.
- udf  out  1  sticky; set by a rejected pop.

## Operation
- **Edge detect**
  - wr_q and rd_q register wr_n and rd_n each cycle; both reset to 0.
  - push_ev = wr_q & ~wr_n; pop_ev = rd_q & ~rd_n. Each is a single-cycle event per falling edge.
  - A strobe held low through reset release causes no event.
- **Storage**
  - mem[DEPTH] of DW bits; wr_ptr and rd_ptr are AW bits and wrap modulo DEPTH.
  - level is a separate AW+1-bit counter; pointer difference alone is not used.
- **Acceptance, evaluated on the same edge from the current level**
  - pop_ok = pop_ev & (level != 0).
  - push_ok = push_ev & ((level != DEPTH) | pop_ok).
- **Simultaneous events**
  - Full with push and pop: both are accepted; level stays DEPTH.
  - Empty with push and pop: the push is accepted, the pop is rejected and udf is set; level becomes 1.
- **Updates**
  - On push_ok: mem[wr_ptr] <= idat; wr_ptr += 1.
  - On pop_ok: rd_ptr += 1.
  - level += push_ok - pop_ok.
- **Errors**
  - push_ev & ~push_ok sets ovf. pop_ev & ~pop_ok sets udf.
  - Rejected operations leave memory, pointers and level unchanged.
  - clr_err clears both flags. If set and clear coincide, set wins.
- **Read data**
  - FWFT=0: on pop_ok, odat <= mem[rd_ptr]; otherwise odat holds.
  - FWFT=1: odat = mem[rd_ptr] combinationally. It is valid only while empty_n=1; a pop advances to the next word.
- **Flags** are decoded combinationally from the registered level.

## Timing
- **Reset values:** pointers=0, level=0, ovf=0, udf=0, odat=0 (FWFT=0), empty_n=0, full_n=1, aempty_n=0, afull_n=1.
- **Memory contents:** not reset.
- **Event timing:** an event fires at the first rising edge where the strobe is sampled low after being sampled high. There is no latency from the strobe edge to that clock edge beyond sampling.
- **After the event edge:** level, the flags and the FWFT=0 odat are all valid immediately after that edge, i.e. 1 cycle of latency.
- **Strobe duty cycle:** the low phase and the high phase must each last at least 1 clk cycle. Each falling edge equals exactly one operation.
- **Reset mid-operation:** asynchronous reset clears all state immediately, with no partial write or pop surviving.

## Test plan
- **Reset defaults:** assert rst low with DW=8, AW=4, then release. Expect level=0, empty_n=0, aempty_n=0, full_n=1, afull_n=1, ovf=0, udf=0 and odat=0x00.
- **Fill and overflow:** push 0x00..0x0F (16 words).
  - After the 16th push: level=16 and full_n=0.
  - afull_n must already be 0 from level 14 onward.
  - A 17th push of 0xAA must be dropped with ovf=1 and level still 16.
- **Drain order (FWFT=0):** pop 16 times. Expect odat=0x00..0x0F in order and empty_n=0 at the end. A further pop must leave odat=0x0F and set udf=1.
- **Full with simultaneous push and pop:** at level=16, make both falling edges land on the same clk edge with idat=0x55.
  - Level must stay 16 and ovf must stay 0.
  - The last of 16 subsequent pops must return 0x55.
- **Wrap-around and FWFT:** with FWFT=1, run 40 interleaved push/pop pairs with incrementing data. Expect odat to equal the head word throughout, level to stay in 0..2, and the pointers to wrap with no data loss.
- **Strobe and error controls:**
  - A strobe held low across reset release, and a strobe held low for 5 cycles, each produce at most one operation.
  - clr_err clears ovf and udf. If a new error occurs in the same cycle as clr_err, its flag remains 1.
